zz_buf: RTL and testbench



---
 rtl/zz_buf.sv | 135 +++++++++++++
 tb/tb_zz_buf.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zz_buf.sv
// Zigzag reorder buffer: raster-order coefficients in, JPEG zigzag-order blocks out.
// Two 64-entry banks ping-pong so one block fills while the other drains.
module zz_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          overflow
);

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [DW-1:0] mem_q [2][64];

    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [5:0]    wi_q, wi_d;
    logic [5:0]    k_q, k_d;
    logic          admit_q, admit_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          doutValid_q, doutValid_d;
    logic          doutLast_q, doutLast_d;
    logic          overflow_q, overflow_d;

    logic          loadEn;
    logic          releaseEn;
    logic          wrFree;
    logic          admitNow;
    logic          wrEn;
    logic [5:0]    zzIdx;

    // A bank drained on this edge counts as free, so back-to-back blocks never stall.
    always_comb begin
        zzIdx     = 6'(ZZ[k_q]);
        loadEn    = full_q[rb_q] && (!doutValid_q || dout_ready);
        releaseEn = loadEn && (k_q == 6'd63);
        wrFree    = !full_q[wb_q] || (releaseEn && (rb_q == wb_q));
        admitNow  = (wi_q == 6'd0) ? wrFree : admit_q;
        wrEn      = din_valid && admitNow;
    end

    always_comb begin
        full_d      = full_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        wi_d        = wi_q;
        k_d         = k_q;
        admit_d     = admit_q;
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        doutLast_d  = doutLast_q;
        overflow_d  = overflow_q;

        if (din_valid) begin
            wi_d = wi_q + 6'd1;
            if (wi_q == 6'd0) begin
                admit_d = wrFree;
                if (!wrFree) begin
                    overflow_d = 1'b1;
                end
            end
        end

        if (loadEn) begin
            dout_d      = mem_q[rb_q][zzIdx];
            doutValid_d = 1'b1;
            doutLast_d  = (k_q == 6'd63);
            k_d         = k_q + 6'd1;
            if (releaseEn) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
            end
        end else if (dout_ready) begin
            doutValid_d = 1'b0;
            doutLast_d  = 1'b0;
        end

        // Set after clear: the write side may refill the bank the read side just released.
        if (wrEn && (wi_q == 6'd63)) begin
            full_d[wb_q] = 1'b1;
            wb_d         = !wb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= 2'b00;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wi_q        <= 6'd0;
            k_q         <= 6'd0;
            admit_q     <= 1'b0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            doutLast_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wi_q        <= wi_d;
            k_q         <= k_d;
            admit_q     <= admit_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            doutLast_q  <= doutLast_d;
            overflow_q  <= overflow_d;
        end
    end

    // Bank storage carries no reset; occupancy is tracked by full_q alone.
    always_ff @(posedge clk) begin
        if (!rst && wrEn) begin
            mem_q[wb_q][wi_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign dout_last  = doutLast_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_zz_buf.sv
// Scoreboard bench for zz_buf: blocks are pushed in zigzag order as they complete,
// and a negedge monitor pops and compares every accepted output.
module tb_zz_buf;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          overflow;

    logic          forceReady;
    logic          randMode;
    logic          rndReady = 1'b1;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            popCount = 0;
    int            lastWriteCyc = 0;
    int            zzOrder [64];
    int            popCycle [$];
    logic [8:0]    sbQ [$];
    logic [7:0]    blk [64];
    bit            expOverflow = 1'b0;

    logic          prevHold = 1'b0;
    logic [DW-1:0] prevDout = '0;
    logic          prevLast = 1'b0;
    logic [8:0]    expEntry;

    assign dout_ready = randMode ? rndReady : forceReady;

    zz_buf #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rndReady <= ($urandom_range(99) < 70);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: held-output stability under backpressure, then scoreboard pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (prevHold) begin
                checkOutput("hold under backpressure", {dout_valid, dout_last, dout},
                            {1'b1, prevLast, prevDout});
            end
            if (dout_valid && dout_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected output", {dout_last, dout}, 9'h1FF);
                    vectors--;
                    vectors++;
                end else begin
                    expEntry = sbQ.pop_front();
                    checkOutput("zigzag output", {dout_last, dout}, expEntry);
                end
                popCount++;
                popCycle.push_back(cyc);
            end
            prevHold = dout_valid && !dout_ready;
            prevDout = dout;
            prevLast = dout_last;
        end else begin
            prevHold = 1'b0;
        end
    end

    task automatic resetDut();
        rst       = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.delete();
        popCycle.delete();
        popCount    = 0;
        expOverflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives blk[] as one raster block; the model queues its zigzag image once complete.
    task automatic applyStimulus(input bit expectAdmit, input int gapPct);
        for (int i = 0; i < 64; i++) begin
            while (gapPct > 0 && $urandom_range(99) < gapPct) begin
                din_valid = 1'b0;
                din       = 8'($urandom);
                @(posedge clk);
                #1;
            end
            din       = blk[i];
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            if (i == 0) begin
                if (!expectAdmit) expOverflow = 1'b1;
                checkOutput("overflow at block start", overflow, expOverflow);
            end
            if (i == 63) begin
                lastWriteCyc = cyc;
                if (expectAdmit) begin
                    for (int k = 0; k < 64; k++) begin
                        sbQ.push_back({(k == 63), blk[zzOrder[k]]});
                    end
                end
            end
        end
    endtask

    task automatic waitDrain(input int budget, input string name);
        int t = 0;
        while ((sbQ.size() > 0 || dout_valid) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput({name, " drained"}, (t < budget), 1);
    endtask

    task automatic checkContig(input int n, input string name);
        int span;
        span = (popCycle.size() > 0) ? popCycle[popCycle.size() - 1] - popCycle[0] : -1;
        checkOutput({name, " output count"}, popCycle.size(), n);
        checkOutput({name, " contiguous span"}, span, n - 1);
    endtask

    initial begin
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zzOrder[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zzOrder[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end

        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        forceReady = 1'b1;
        randMode   = 1'b0;
        idle(3);
        resetDut();

        checkOutput("reset dout_valid", dout_valid, 0);
        checkOutput("reset dout_last", dout_last, 0);
        checkOutput("reset dout", dout, 0);
        checkOutput("reset overflow", overflow, 0);

        // Ordering: raster index as data exposes the zigzag table directly.
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        applyStimulus(1'b1, 0);
        waitDrain(200, "ordering");
        checkContig(64, "ordering");
        if (popCycle.size() > 0)
            checkOutput("first output latency", popCycle[0] - lastWriteCyc, 1);
        else
            checkOutput("first output latency", 0, 1);

        $display("[TB] signed pass-through");
        resetDut();
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        blk[0] = 8'h80;
        blk[1] = 8'h7F;
        blk[8] = 8'hFF;
        applyStimulus(1'b1, 0);
        waitDrain(200, "signed");

        $display("[TB] backpressure on 5th output");
        resetDut();
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        applyStimulus(1'b1, 0);
        begin
            int t = 0;
            while (!(dout_valid && popCount == 4) && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            checkOutput("reached 5th output", (t < 200), 1);
        end
        forceReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held ZZ[4]", {dout_valid, dout}, {1'b1, 8'd9});
        end
        @(posedge clk);
        #1;
        forceReady = 1'b1;
        waitDrain(200, "backpressure");
        checkOutput("backpressure output count", popCount, 64);

        $display("[TB] overflow with three queued blocks");
        resetDut();
        forceReady = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            for (int i = 0; i < 64; i++) blk[i] = 8'(b);
            applyStimulus(b != 3, 0);
        end
        forceReady = 1'b1;
        waitDrain(400, "overflow");
        idle(20);
        checkOutput("overflow output count", popCount, 128);
        checkOutput("overflow sticky", overflow, 1);
        resetDut();
        checkOutput("overflow cleared by reset", overflow, 0);

        $display("[TB] streaming four blocks");
        resetDut();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
            applyStimulus(1'b1, 0);
        end
        waitDrain(400, "streaming");
        checkContig(256, "streaming");
        checkOutput("streaming overflow", overflow, 0);

        $display("[TB] reset mid-block");
        resetDut();
        for (int i = 0; i < 30; i++) begin
            din       = 8'd5;
            din_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        resetDut();
        checkOutput("after reset dout", {dout_valid, dout}, 0);
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        applyStimulus(1'b1, 0);
        waitDrain(200, "reset mid-block");
        checkContig(64, "reset mid-block");

        $display("[TB] random data, gaps and ready");
        resetDut();
        randMode = 1'b1;
        for (int b = 0; b < 6; b++) begin
            if (b >= 2) begin
                int t = 0;
                while (popCount < (b - 1) * 64 && t < 3000) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                checkOutput("random pacing", (popCount >= (b - 1) * 64), 1);
            end
            for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
            applyStimulus(1'b1, 30);
        end
        waitDrain(3000, "random");
        randMode = 1'b0;
        checkOutput("random output count", popCount, 384);
        checkOutput("random overflow", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
